// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the memory stage: funct3 encodings, LSU FSM states,
// and the lane helpers that turn size and offset into byte enables and store data.
package riscv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   // funct3[1:0] = 11 never comes out of the decoder and is handled as a word access.
   function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      case (f3[1:0])
         2'b00:   ok = 1'b1;
         2'b01:   ok = ~off[0];
         default: ok = (off == 2'b00);
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << {off[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] rs2);
      logic [31:0] d;
      case (f3[1:0])
         2'b00:   d = {4{rs2[7:0]}};
         2'b01:   d = {2{rs2[15:0]}};
         default: d = rs2;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a loaded word and sign- or zero-extends it.
module lsu_load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] wb_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic        sext_s;

   // Lane select followed by extension; funct3[2] marks the unsigned variants.
   always_comb begin
      case (offset)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      if (offset[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
      sext_s = ~funct3[2];
      case (funct3[1:0])
         2'b00:   wb_data = {{24{byte_s[7] & sext_s}}, byte_s};
         2'b01:   wb_data = {{16{half_s[15] & sext_s}}, half_s};
         default: wb_data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_stage.sv
// Memory-stage load/store unit: one request/grant/response transaction per memory
// instruction, with the pipeline held until the transaction completes.
module lsu_stage
   import riscv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int DMEM_AW = 30
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               in_load,
   input  logic               in_store,
   input  logic [2:0]         in_funct3,
   input  logic [XLEN-1:0]    in_addr,
   input  logic [XLEN-1:0]    in_wdata,
   input  logic [4:0]         in_rd,
   input  logic               flush,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [3:0]         dmem_be,
   output logic [XLEN-1:0]    dmem_wdata,
   input  logic               dmem_gnt,
   input  logic               dmem_rvalid,
   input  logic [XLEN-1:0]    dmem_rdata,
   output logic               lsu_stall,
   output logic               wb_valid,
   output logic [4:0]         wb_rd,
   output logic [XLEN-1:0]    wb_data,
   output logic               misalign,
   output logic [XLEN-1:0]    misalign_addr
);

   lsu_state_t         state_r, state_nxt_s;
   logic               mem_op_s, aligned_s, accept_s, fault_s, resp_hit_s;
   logic               req_s, stall_s;
   logic               we_r;
   logic [DMEM_AW-1:0] addr_r;
   logic [3:0]         be_r;
   logic [XLEN-1:0]    wdata_r;
   logic [2:0]         funct3_r;
   logic [1:0]         off_r;
   logic [4:0]         rd_r;
   logic               wb_valid_r, misalign_r;
   logic [4:0]         wb_rd_r;
   logic [XLEN-1:0]    wb_data_r, misalign_addr_r, align_s;

   assign mem_op_s   = in_valid & (in_load | in_store) & ~flush;
   assign aligned_s  = is_aligned(in_funct3, in_addr[1:0]);
   assign accept_s   = (state_r == IDLE) & mem_op_s & aligned_s;
   assign fault_s    = (state_r == IDLE) & mem_op_s & ~aligned_s;
   assign resp_hit_s = (state_r == RESP) & dmem_rvalid;

   lsu_load_align u_align (
      .rdata   (dmem_rdata),
      .offset  (off_r),
      .funct3  (funct3_r),
      .wb_data (align_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; once in REQ or RESP the bus transaction always runs to completion.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = REQ;
            else          state_nxt_s = IDLE;
         end
         REQ: begin
            if (dmem_gnt) state_nxt_s = we_r ? DONE : RESP;
            else          state_nxt_s = REQ;
         end
         RESP: begin
            if (dmem_rvalid) state_nxt_s = DONE;
            else             state_nxt_s = RESP;
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs: request follows the state register so reset drops it immediately.
   always_comb begin
      req_s   = 1'b0;
      stall_s = 1'b0;
      case (state_r)
         IDLE:    stall_s = accept_s;
         REQ: begin
            req_s   = 1'b1;
            stall_s = 1'b1;
         end
         RESP:    stall_s = 1'b1;
         DONE:    stall_s = 1'b0;
         default: stall_s = 1'b0;
      endcase
   end

   // Transaction capture, writeback and misalign registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_r            <= 1'b0;
         addr_r          <= '0;
         be_r            <= 4'b0000;
         wdata_r         <= '0;
         funct3_r        <= 3'b000;
         off_r           <= 2'b00;
         rd_r            <= 5'd0;
         wb_valid_r      <= 1'b0;
         wb_rd_r         <= 5'd0;
         wb_data_r       <= '0;
         misalign_r      <= 1'b0;
         misalign_addr_r <= '0;
      end else begin
         if (accept_s) begin
            we_r     <= in_store;
            addr_r   <= in_addr[XLEN-1:XLEN-DMEM_AW];
            be_r     <= byte_en(in_funct3, in_addr[1:0]);
            wdata_r  <= lane_data(in_funct3, in_wdata);
            funct3_r <= in_funct3;
            off_r    <= in_addr[1:0];
            rd_r     <= in_rd;
         end
         wb_valid_r <= resp_hit_s;
         if (resp_hit_s) begin
            wb_data_r <= align_s;
            wb_rd_r   <= rd_r;
         end
         misalign_r <= fault_s;
         if (fault_s) begin
            misalign_addr_r <= in_addr;
         end
      end
   end

   assign dmem_req      = req_s;
   assign dmem_we       = we_r;
   assign dmem_addr     = addr_r;
   assign dmem_be       = be_r;
   assign dmem_wdata    = wdata_r;
   assign lsu_stall     = stall_s;
   assign wb_valid      = wb_valid_r;
   assign wb_rd         = wb_rd_r;
   assign wb_data       = wb_data_r;
   assign misalign      = misalign_r;
   assign misalign_addr = misalign_addr_r;

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: expected requests, writebacks and faults are queued
// at issue time and compared as the DUT produces them.
module tb_lsu_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_load, in_store, flush;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [29:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata, dmem_rdata;
   logic        lsu_stall, wb_valid, misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, misalign_addr;

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   req_t        exp_req_q[$];
   wb_t         exp_wb_q[$];
   logic [31:0] exp_mis_q[$];

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   lsu_stage #(.XLEN(32), .DMEM_AW(30)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .flush(flush),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .lsu_stall(lsu_stall),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .misalign(misalign), .misalign_addr(misalign_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
      logic [31:0] sh;
      sh = w >> (8 * off);
      case (f3)
         3'b000:  return (sh[7]  ? 32'hFFFFFF00 : 32'h0) | (sh & 32'h000000FF);
         3'b100:  return sh & 32'h000000FF;
         3'b001:  return (sh[15] ? 32'hFFFF0000 : 32'h0) | (sh & 32'h0000FFFF);
         3'b101:  return sh & 32'h0000FFFF;
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
      if (f3[1:0] == 2'b00) begin
         case (off)
            2'd0: return 4'b0001;
            2'd1: return 4'b0010;
            2'd2: return 4'b0100;
            default: return 4'b1000;
         endcase
      end else if (f3[1:0] == 2'b01) begin
         return off[1] ? 4'b1100 : 4'b0011;
      end else begin
         return 4'b1111;
      end
   endfunction

   // Issue one instruction, act as data memory, and retire it when stall drops.
   task automatic run_op(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] rdat, input int gnt_dly, input int rv_dly,
                         input logic fl, input logic rst_resp);
      logic al, acc, mis;
      int   reqc, stallc, misc, resp_cnt, tail;
      logic gnt_seen, retired, done, stall_now;
      req_t cur, e;
      wb_t  w;
      logic [31:0] ma;
      al  = (f3[1:0] == 2'b00) || (f3[1:0] == 2'b01 && !addr[0]) || (addr[1:0] == 2'b00);
      acc = (ld || st) && !fl && al;
      mis = (ld || st) && !fl && !al;
      if (acc) begin
         e.we    = st;
         e.addr  = addr[31:2];
         e.be    = ref_be(f3, addr[1:0]);
         e.wdata = (f3[1:0] == 2'b00) ? {4{wd[7:0]}} : (f3[1:0] == 2'b01) ? {2{wd[15:0]}} : wd;
         exp_req_q.push_back(e);
         if (ld) begin
            w.rd   = rd;
            w.data = ref_load(f3, addr[1:0], rdat);
            exp_wb_q.push_back(w);
         end
      end
      if (mis) exp_mis_q.push_back(addr);
      cur = '{1'b0, 30'd0, 4'd0, 32'd0};
      in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3;
      in_addr = addr; in_wdata = wd; in_rd = rd; flush = fl;
      reqc = 0; stallc = 0; misc = 0; resp_cnt = 0; tail = 0;
      gnt_seen = 1'b0; retired = 1'b0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (lsu_stall) stallc++;
         if (dmem_req) begin
            if (reqc == 0) begin
               if (exp_req_q.size() > 0) begin
                  cur = exp_req_q.pop_front();
                  chk({nm, " we"}, {31'd0, dmem_we}, {31'd0, cur.we});
                  chk({nm, " addr"}, {2'b00, dmem_addr}, {2'b00, cur.addr});
                  chk({nm, " be"}, {28'd0, dmem_be}, {28'd0, cur.be});
                  if (cur.we) chk({nm, " wdata"}, dmem_wdata, cur.wdata);
               end else begin
                  chk({nm, " unexpected req"}, 32'd1, 32'd0);
               end
            end else begin
               chk({nm, " req addr stable"}, {2'b00, dmem_addr}, {2'b00, cur.addr});
               chk({nm, " req be stable"}, {28'd0, dmem_be}, {28'd0, cur.be});
            end
            reqc++;
         end
         if (wb_valid) begin
            if (exp_wb_q.size() > 0) begin
               w = exp_wb_q.pop_front();
               chk({nm, " wb_data"}, wb_data, w.data);
               chk({nm, " wb_rd"}, {27'd0, wb_rd}, {27'd0, w.rd});
            end else begin
               chk({nm, " unexpected wb_valid"}, 32'd1, 32'd0);
            end
         end
         if (misalign) begin
            misc++;
            if (exp_mis_q.size() > 0) begin
               ma = exp_mis_q.pop_front();
               chk({nm, " misalign_addr"}, misalign_addr, ma);
            end else if (misc == 1) begin
               chk({nm, " unexpected misalign"}, 32'd1, 32'd0);
            end
         end
         dmem_gnt    = dmem_req && (reqc == gnt_dly + 1);
         dmem_rvalid = 1'b0;
         dmem_rdata  = $urandom;
         if (gnt_seen) begin
            resp_cnt++;
            if (rst_resp && resp_cnt == 1) begin
               dmem_gnt = 1'b0;
               in_valid = 1'b0;
               rst_n    = 1'b0;
               #1;
               chk({nm, " rst req"}, {31'd0, dmem_req}, 32'd0);
               chk({nm, " rst stall"}, {31'd0, lsu_stall}, 32'd0);
               chk({nm, " rst addr"}, {2'b00, dmem_addr}, 32'd0);
               chk({nm, " rst be"}, {28'd0, dmem_be}, 32'd0);
               chk({nm, " rst wb_valid"}, {31'd0, wb_valid}, 32'd0);
               chk({nm, " rst wb_data"}, wb_data, 32'd0);
               if (exp_wb_q.size() > 0) w = exp_wb_q.pop_front();
               @(posedge clk); #1;
               rst_n = 1'b1;
               done  = 1'b1;
               continue;
            end else if (resp_cnt == rv_dly) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = rdat;
            end
         end
         if (dmem_gnt) gnt_seen = 1'b1;
         stall_now = lsu_stall;
         @(posedge clk); #1;
         dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
         if (retired) begin
            tail++;
            if (tail == 2) done = 1'b1;
         end else if (!stall_now) begin
            retired  = 1'b1;
            in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; flush = 1'b0;
         end
      end
      if (!done) chk({nm, " timeout"}, 32'd0, 32'd1);
      if (!rst_resp) begin
         chk({nm, " stall cycles"}, stallc, acc ? (2 + gnt_dly + (ld ? rv_dly : 0)) : 0);
         chk({nm, " req cycles"}, reqc, acc ? gnt_dly + 1 : 0);
         chk({nm, " misalign pulses"}, misc, mis ? 1 : 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; flush = 1'b0;
      in_funct3 = 3'b000; in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset req", {31'd0, dmem_req}, 32'd0);
      chk("reset we", {31'd0, dmem_we}, 32'd0);
      chk("reset addr", {2'b00, dmem_addr}, 32'd0);
      chk("reset be", {28'd0, dmem_be}, 32'd0);
      chk("reset wdata", dmem_wdata, 32'd0);
      chk("reset stall", {31'd0, lsu_stall}, 32'd0);
      chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("reset wb_rd", {27'd0, wb_rd}, 32'd0);
      chk("reset wb_data", wb_data, 32'd0);
      chk("reset misalign", {31'd0, misalign}, 32'd0);
      chk("reset misalign_addr", misalign_addr, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      //     name     ld    st    f3      addr          wdata         rd     rdata         g  rv fl    rst
      run_op("SW",    1'b0, 1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 5'd0,  32'h0,        1, 1, 1'b0, 1'b0);
      run_op("SB",    1'b0, 1'b1, 3'b000, 32'h00000103, 32'h000000A5, 5'd0,  32'h0,        0, 1, 1'b0, 1'b0);
      run_op("SH",    1'b0, 1'b1, 3'b001, 32'h00000102, 32'h00001234, 5'd0,  32'h0,        0, 1, 1'b0, 1'b0);
      run_op("SB1",   1'b0, 1'b1, 3'b000, 32'h00000401, 32'h0000003C, 5'd0,  32'h0,        2, 1, 1'b0, 1'b0);
      run_op("LB",    1'b1, 1'b0, 3'b000, 32'h00000201, 32'h0,        5'd5,  32'h00008000, 0, 1, 1'b0, 1'b0);
      run_op("LBU",   1'b1, 1'b0, 3'b100, 32'h00000201, 32'h0,        5'd6,  32'h00008000, 0, 1, 1'b0, 1'b0);
      run_op("LH",    1'b1, 1'b0, 3'b001, 32'h00000202, 32'h0,        5'd9,  32'h80010000, 0, 2, 1'b0, 1'b0);
      run_op("LHU",   1'b1, 1'b0, 3'b101, 32'h00000206, 32'h0,        5'd10, 32'h9ABC1234, 1, 1, 1'b0, 1'b0);
      run_op("LB3",   1'b1, 1'b0, 3'b000, 32'h00000203, 32'h0,        5'd11, 32'h7F001122, 0, 1, 1'b0, 1'b0);
      run_op("LW",    1'b1, 1'b0, 3'b010, 32'h00000300, 32'h0,        5'd7,  32'hCAFEF00D, 0, 3, 1'b0, 1'b0);
      run_op("LW2",   1'b1, 1'b0, 3'b010, 32'h00000304, 32'h0,        5'd8,  32'h01234567, 0, 1, 1'b0, 1'b0);
      run_op("LWmis", 1'b1, 1'b0, 3'b010, 32'h00000102, 32'h0,        5'd3,  32'h0,        0, 1, 1'b0, 1'b0);
      run_op("LHmis", 1'b1, 1'b0, 3'b001, 32'h00000201, 32'h0,        5'd3,  32'h0,        0, 1, 1'b0, 1'b0);
      run_op("SHmis", 1'b0, 1'b1, 3'b001, 32'h00000203, 32'h0000FFFF, 5'd0,  32'h0,        0, 1, 1'b0, 1'b0);
      run_op("SWfl",  1'b0, 1'b1, 3'b010, 32'h00000100, 32'h11111111, 5'd0,  32'h0,        0, 1, 1'b1, 1'b0);
      run_op("LWmfl", 1'b1, 1'b0, 3'b010, 32'h00000102, 32'h0,        5'd2,  32'h0,        0, 1, 1'b1, 1'b0);
      run_op("ALU",   1'b0, 1'b0, 3'b010, 32'h00000500, 32'h0,        5'd4,  32'h0,        0, 1, 1'b0, 1'b0);
      run_op("LWrst", 1'b1, 1'b0, 3'b010, 32'h00000600, 32'h0,        5'd12, 32'h55AA55AA, 0, 3, 1'b0, 1'b1);
      @(posedge clk); #1;
      run_op("LWpost", 1'b1, 1'b0, 3'b010, 32'h00000700, 32'h0,       5'd13, 32'hA5A50F0F, 1, 2, 1'b0, 1'b0);
      chk("req queue empty", exp_req_q.size(), 32'd0);
      chk("wb queue empty", exp_wb_q.size(), 32'd0);
      chk("misalign queue empty", exp_mis_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
Memory-stage load/store unit. It sits directly downstream of the execute-stage ALU and uses the ALU result as the effective address.
- Generates byte enables and lane-replicated store data.
- Runs a request/grant/response handshake with data memory.
- Sign- or zero-extends load data for writeback.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
XLEN, 32, data and address width (only 32 is supported)
DMEM_AW, 30, word-address width driven to data memory (address bits [31:2])

Ports:
clk  in  1  system clock
rst_n  in  1  reset
in_valid  in  1  EX/MEM register holds a valid instruction
in_load  in  1  instruction is a load
in_store  in  1  instruction is a store
in_funct3  in  3  RISC-V funct3 (size and signedness)
in_addr  in  32  effective address (ALU result)
in_wdata  in  32  rs2 store data
in_rd  in  5  destination register
flush  in  1  kill the current EX/MEM instruction
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  DMEM_AW  word address
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read word
lsu_stall  out  1  hold all upstream stages
wb_valid  out  1  load result valid (one-cycle pulse)
wb_rd  out  5  load destination
wb_data  out  32  extended load data
misalign  out  1  misaligned-access exception (one-cycle pulse)
misalign_addr  out  32  faulting address

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; dmem_req, dmem_we, wb_valid, misalign = 0; dmem_addr, dmem_be, dmem_wdata, wb_rd, wb_data, misalign_addr = 0.
- Definitions:
  - mem_op = in_valid & (in_load | in_store) & ~flush.
  - Aligned means: byte access always; halfword needs addr[0]=0; word needs addr[1:0]=0.
  - funct3[1:0]=11 is treated as word. The decoder never issues it.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - mem_op & aligned: capture we, addr[31:2], be, wdata, funct3, rd and addr[1:0]; go to REQ.
  - mem_op & misaligned: no request. Register misalign=1 and misalign_addr=in_addr for exactly one cycle; stay IDLE.
- REQ:
  - dmem_req=1. All dmem_* outputs come from captured registers and stay stable until dmem_gnt.
  - gnt & store: go to DONE.
  - gnt & load: go to RESP.
  - dmem_req drops in the cycle after gnt.
- RESP: wait for dmem_rvalid, which arrives no earlier than the cycle after gnt. On rvalid, register the extended data into wb_data and set wb_rd; go to DONE.
- DONE: wb_valid=1 for one cycle (loads only; stores give wb_valid=0). Go to IDLE.
- lsu_stall (combinational) = (IDLE & mem_op & aligned) | REQ | RESP.
  - Stall is 0 in DONE, so the pipeline advances exactly once per memory op.
  - IDLE never re-accepts the same instruction.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111; wdata = rs2.
- Load extract: select the byte or halfword with the captured addr[1:0], then extend:
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: unchanged.
- Flush:
  - In IDLE, flush suppresses acceptance and misalign.
  - In REQ or RESP, flush is ignored; bus transactions are never abandoned.
- Reset mid-transaction: FSM returns to IDLE immediately and dmem_req drops asynchronously. The memory model must tolerate an orphaned grant.
- Non-memory instructions pass through with no effect and no stall.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - lsu_state_t enum {IDLE, REQ, RESP, DONE}.
- Combinational sub-module lsu_load_align (rdata, offset, funct3 -> wb_data) holds the extraction/extension logic. It is reused by the verification reference model.

Test Plan:
- SW addr=0x100, rs2=0xDEADBEEF, gnt on 2nd REQ cycle -> dmem_addr=0x40, be=1111, wdata=0xDEADBEEF. Request is held 2 cycles; stall high 3 cycles, then DONE; wb_valid stays 0.
- SB addr=0x103, rs2=0x000000A5 -> be=1000, wdata=0xA5A5A5A5.
- SH addr=0x102, rs2=0x00001234 -> be=1100, wdata=0x12341234.
- LB addr=0x201, rdata=0x00008000 -> wb_data=0xFFFFFF80.
- LBU on the same address and data -> wb_data=0x00000080.
- LH addr=0x202, rdata=0x80010000 -> wb_data=0xFFFF8001.
- LW with gnt immediately and rvalid 3 cycles later -> stall held through RESP; one wb_valid pulse with wb_rd as issued; a following instruction is accepted only after DONE.
- LW addr=0x102 -> misalign=1 for one cycle, misalign_addr=0x102, dmem_req never asserted, lsu_stall=0.
- SW with flush=1 in IDLE -> no request. rst_n pulled low while in RESP -> outputs return to reset values immediately, and the next valid LW is serviced normally.
